// File: rtl/operand_align.sv
// Operand alignment stage for single-precision add/subtract.
// Chooses the larger-exponent operand and right-shifts the other one,
// one bit per clock, until both share that exponent. The bits shifted
// out are kept as guard, round and sticky.
module operand_align (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  exp1,
  input  logic [7:0]  exp2,
  input  logic [22:0] sig1,
  input  logic [22:0] sig2,
  input  logic [1:0]  n_concat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_out,
  output logic [23:0] sig_big,
  output logic [23:0] sig_small,
  output logic [2:0]  grs,
  output logic        swapped
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // The maximum useful shift is 27 (24 mantissa bits plus 3 guard bits).
  localparam logic [4:0] MAX_SHIFT = 5'd27;

  state_t      state_reg;
  logic [7:0]  exp_out_reg;
  logic [23:0] sig_big_reg;
  logic [26:0] align_reg;
  logic [4:0]  count_reg;
  logic        swapped_reg;

  logic        swap_sel;
  logic [7:0]  exp_diff;
  logic [4:0]  shift_cnt;
  logic [23:0] man1;
  logic [23:0] man2;

  // Operand comparison and shift count for the pair on the inputs.
  // Equal exponents keep op1 as the "big" operand; the significands are
  // never compared.
  always_comb begin
    swap_sel  = (exp2 > exp1);
    exp_diff  = swap_sel ? (exp2 - exp1) : (exp1 - exp2);
    shift_cnt = (exp_diff > 8'd27) ? MAX_SHIFT : exp_diff[4:0];
    man1      = {~n_concat[1], sig1};
    man2      = {~n_concat[0], sig2};
  end

  // Control and datapath registers: accept, shift one bit per cycle, hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      exp_out_reg <= 8'd0;
      sig_big_reg <= 24'd0;
      align_reg   <= 27'd0;
      count_reg   <= 5'd0;
      swapped_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            swapped_reg <= swap_sel;
            exp_out_reg <= swap_sel ? exp2 : exp1;
            sig_big_reg <= swap_sel ? man2 : man1;
            align_reg   <= {(swap_sel ? man1 : man2), 3'b000};
            count_reg   <= shift_cnt;
            state_reg   <= (shift_cnt == 5'd0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          // Logical right shift; the bit leaving position 0 is ORed into
          // the new position 0 so the sticky bit accumulates.
          align_reg <= {1'b0, align_reg[26:2], align_reg[1] | align_reg[0]};
          count_reg <= count_reg - 5'd1;
          if (count_reg == 5'd1) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Output decode. The aligned significand is only exposed once shifting
  // has finished so intermediate shift states never appear on sig_small.
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    exp_out   = exp_out_reg;
    sig_big   = sig_big_reg;
    swapped   = swapped_reg;
    sig_small = (state_reg == DONE) ? align_reg[26:3] : 24'd0;
    grs       = (state_reg == DONE) ? align_reg[2:0]  : 3'd0;
  end

endmodule
